fifo_sync_tpsram_prefetch: RTL and testbench



---
 rtl/fifo_sync_tpsram_prefetch_if.sv | 47 ++++
 rtl/fifo_sync_tpsram_prefetch.sv | 117 +++++++++++
 tb/tb_fifo_sync_tpsram_prefetch.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_tpsram_prefetch_if.sv
// Bus bundle for the tpsram prefetch FIFO: client push/pop side,
// status flags and the two-port SRAM strobes.
interface fifo_sync_tpsram_prefetch_if #(
  parameter int WIDTH   = 64,
  parameter int AW      = 6,
  parameter int CNT_WID = 8
);
  logic               fifo_init;
  logic               fifo_push;
  logic [WIDTH-1:0]   fifo_data_in;
  logic               fifo_full;
  logic               fifo_afull;
  logic               fifo_pop;
  logic               fifo_valid;
  logic [WIDTH-1:0]   fifo_data_out;
  logic               fifo_empty;
  logic               fifo_aempty;
  logic [CNT_WID-1:0] fifo_word_cnt;
  logic               fifo_ovf;
  logic               fifo_udf;
  logic               sram_re;
  logic [AW-1:0]      sram_raddr;
  logic               sram_we;
  logic [AW-1:0]      sram_waddr;
  logic [WIDTH-1:0]   sram_wdata;
  logic [WIDTH-1:0]   sram_rdata;

  modport master (
    output fifo_init, fifo_push, fifo_data_in,
    output fifo_pop, sram_rdata,
    input  fifo_full, fifo_afull, fifo_valid,
    input  fifo_data_out, fifo_empty, fifo_aempty,
    input  fifo_word_cnt, fifo_ovf, fifo_udf,
    input  sram_re, sram_raddr, sram_we,
    input  sram_waddr, sram_wdata
  );

  modport slave (
    input  fifo_init, fifo_push, fifo_data_in,
    input  fifo_pop, sram_rdata,
    output fifo_full, fifo_afull, fifo_valid,
    output fifo_data_out, fifo_empty, fifo_aempty,
    output fifo_word_cnt, fifo_ovf, fifo_udf,
    output sram_re, sram_raddr, sram_we,
    output sram_waddr, sram_wdata
  );
endinterface

// File: rtl/fifo_sync_tpsram_prefetch.sv
// Synchronous FIFO on an external two-port SRAM with a credit-based
// prefetch buffer giving a first-word-fall-through valid/pop output.
module fifo_sync_tpsram_prefetch #(
  parameter int FIFO_WIDTH = 64,
  parameter int FIFO_DEPTH = 64,
  parameter int RD_LAT     = 1,
  parameter int AFULL_TH   = FIFO_DEPTH - 2,
  parameter int AEMPTY_TH  = 2
) (
  input logic clk,
  input logic rst,
  fifo_sync_tpsram_prefetch_if.slave bus
);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int OUT_DEPTH = RD_LAT + 1;
  localparam int CNT_WID   = AW + 2;
  localparam int OW        = 3;

  logic                  flush;
  logic [AW:0]           wptr_q;
  logic [AW:0]           rptr_q;
  logic                  mem_empty;
  logic                  mem_full;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  rd_en;
  logic                  ret_vld;
  logic [RD_LAT-1:0]     infl_q;
  logic [OW-1:0]         infl_cnt;
  logic [OW-1:0]         occ;
  logic [OW-1:0]         obuf_cnt_q;
  logic [OW-1:0]         obuf_cnt_d;
  logic [OW-1:0]         wr_idx;
  logic [FIFO_WIDTH-1:0] obuf_q [OUT_DEPTH];
  logic [FIFO_WIDTH-1:0] obuf_d [OUT_DEPTH];
  logic [CNT_WID-1:0]    cnt_q;
  logic                  ovf_q;
  logic                  udf_q;

  assign flush     = rst || bus.fifo_init;
  assign mem_empty = rptr_q == wptr_q;
  assign mem_full  = (rptr_q[AW] != wptr_q[AW]) &&
                     (rptr_q[AW-1:0] == wptr_q[AW-1:0]);

  assign push_acc = bus.fifo_push && !mem_full && !flush;
  assign pop_acc  = bus.fifo_pop && (obuf_cnt_q != '0) && !flush;

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++)
      infl_cnt = infl_cnt + OW'(infl_q[i]);
  end

  // Words already claimed (buffered or in flight) never exceed OUT_DEPTH.
  assign occ     = obuf_cnt_q + infl_cnt;
  assign rd_en   = !mem_empty && !flush &&
                   (occ < OW'(OUT_DEPTH) + OW'(pop_acc));
  assign ret_vld = infl_q[RD_LAT-1];
  assign wr_idx  = obuf_cnt_q - OW'(pop_acc);

  always_comb begin
    obuf_d     = obuf_q;
    obuf_cnt_d = obuf_cnt_q;
    if (pop_acc) begin
      for (int i = 0; i < OUT_DEPTH - 1; i++)
        obuf_d[i] = obuf_q[i+1];
      obuf_d[OUT_DEPTH-1] = '0;
      obuf_cnt_d = obuf_cnt_q - 1'b1;
    end
    if (ret_vld) begin
      for (int i = 0; i < OUT_DEPTH; i++)
        if (OW'(i) == wr_idx) obuf_d[i] = bus.sram_rdata;
      obuf_cnt_d = obuf_cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      infl_q     <= '0;
      obuf_cnt_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++)
        obuf_q[i] <= '0;
    end else begin
      if (push_acc) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
      for (int i = RD_LAT - 1; i > 0; i--)
        infl_q[i] <= infl_q[i-1];
      infl_q[0]  <= rd_en;
      obuf_q     <= obuf_d;
      obuf_cnt_q <= obuf_cnt_d;
      cnt_q      <= cnt_q + CNT_WID'(push_acc)
                         - CNT_WID'(pop_acc);
      if (bus.fifo_push && mem_full) ovf_q <= 1'b1;
      if (bus.fifo_pop && obuf_cnt_q == '0) udf_q <= 1'b1;
    end
  end

  assign bus.fifo_full     = mem_full;
  assign bus.fifo_afull    = cnt_q >= CNT_WID'(AFULL_TH);
  assign bus.fifo_aempty   = cnt_q <= CNT_WID'(AEMPTY_TH);
  assign bus.fifo_empty    = cnt_q == '0;
  assign bus.fifo_word_cnt = cnt_q;
  assign bus.fifo_valid    = obuf_cnt_q != '0;
  assign bus.fifo_data_out = obuf_q[0];
  assign bus.fifo_ovf      = ovf_q;
  assign bus.fifo_udf      = udf_q;
  assign bus.sram_we       = push_acc;
  assign bus.sram_waddr    = wptr_q[AW-1:0];
  assign bus.sram_wdata    = bus.fifo_data_in;
  assign bus.sram_re       = rd_en;
  assign bus.sram_raddr    = rptr_q[AW-1:0];
endmodule

// File: tb/tb_fifo_sync_tpsram_prefetch.sv
// Bench: RD_LAT=1 and RD_LAT=2 instances side by side, each with an
// SRAM model and a queue-based reference of the FIFO contents.
module tb_fifo_sync_tpsram_prefetch;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  logic push;
  logic init;
  logic [W-1:0] din;
  logic pop [2];
  bit mon_en = 1'b0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_sync_tpsram_prefetch_if #(.WIDTH(W), .AW(AW), .CNT_WID(CW)) bus_a ();
  fifo_sync_tpsram_prefetch_if #(.WIDTH(W), .AW(AW), .CNT_WID(CW)) bus_b ();

  fifo_sync_tpsram_prefetch #(
    .FIFO_WIDTH(W), .FIFO_DEPTH(D), .RD_LAT(1),
    .AFULL_TH(6), .AEMPTY_TH(2)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );

  fifo_sync_tpsram_prefetch #(
    .FIFO_WIDTH(W), .FIFO_DEPTH(D), .RD_LAT(2),
    .AFULL_TH(6), .AEMPTY_TH(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  logic [W-1:0] mem_a [D];
  logic [W-1:0] mem_b [D];
  logic [W-1:0] rd_a  = '0;
  logic [W-1:0] rd_b1 = '0;
  logic [W-1:0] rd_b2 = '0;

  always @(posedge clk) begin
    if (bus_a.sram_we) mem_a[bus_a.sram_waddr] <= bus_a.sram_wdata;
    if (bus_a.sram_re) rd_a <= mem_a[bus_a.sram_raddr];
    if (bus_b.sram_we) mem_b[bus_b.sram_waddr] <= bus_b.sram_wdata;
    if (bus_b.sram_re) rd_b1 <= mem_b[bus_b.sram_raddr];
    rd_b2 <= rd_b1;
  end

  assign bus_a.fifo_init    = init;
  assign bus_a.fifo_push    = push;
  assign bus_a.fifo_data_in = din;
  assign bus_a.fifo_pop     = pop[0];
  assign bus_a.sram_rdata   = rd_a;
  assign bus_b.fifo_init    = init;
  assign bus_b.fifo_push    = push;
  assign bus_b.fifo_data_in = din;
  assign bus_b.fifo_pop     = pop[1];
  assign bus_b.sram_rdata   = rd_b2;

  logic         vld [2], full [2], afull [2], aempty [2];
  logic         empty [2], ovf [2], udf [2], re [2], we [2];
  logic [W-1:0] dout [2];
  logic [CW-1:0] cnt [2];

  assign vld[0]    = bus_a.fifo_valid;
  assign vld[1]    = bus_b.fifo_valid;
  assign full[0]   = bus_a.fifo_full;
  assign full[1]   = bus_b.fifo_full;
  assign afull[0]  = bus_a.fifo_afull;
  assign afull[1]  = bus_b.fifo_afull;
  assign aempty[0] = bus_a.fifo_aempty;
  assign aempty[1] = bus_b.fifo_aempty;
  assign empty[0]  = bus_a.fifo_empty;
  assign empty[1]  = bus_b.fifo_empty;
  assign ovf[0]    = bus_a.fifo_ovf;
  assign ovf[1]    = bus_b.fifo_ovf;
  assign udf[0]    = bus_a.fifo_udf;
  assign udf[1]    = bus_b.fifo_udf;
  assign re[0]     = bus_a.sram_re;
  assign re[1]     = bus_b.sram_re;
  assign we[0]     = bus_a.sram_we;
  assign we[1]     = bus_b.sram_we;
  assign dout[0]   = bus_a.fifo_data_out;
  assign dout[1]   = bus_b.fifo_data_out;
  assign cnt[0]    = bus_a.fifo_word_cnt;
  assign cnt[1]    = bus_b.fifo_word_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference: contents as a queue, sticky flags, words claimed from SRAM.
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  logic         movf [2];
  logic         mudf [2];
  int           outst [2];

  initial begin
    movf = '{1'b0, 1'b0};
    mudf = '{1'b0, 1'b0};
    outst = '{0, 0};
  end

  task automatic mon(input int k);
    int sz;
    logic [W-1:0] head;
    string p;
    p = (k == 0) ? "a." : "b.";
    sz = (k == 0) ? q0.size() : q1.size();
    head = '0;
    if (sz > 0) head = (k == 0) ? q0[0] : q1[0];
    chk({p, "cnt"}, cnt[k], sz);
    chk({p, "empty"}, empty[k], sz == 0);
    chk({p, "afull"}, afull[k], sz >= 6);
    chk({p, "aempty"}, aempty[k], sz <= 2);
    chk({p, "ovf"}, ovf[k], movf[k]);
    chk({p, "udf"}, udf[k], mudf[k]);
    chk({p, "vld_nonempty"}, vld[k] && sz == 0, 0);
    if (vld[k] && sz > 0) chk({p, "dout"}, dout[k], head);
    chk({p, "obuf_bound"}, outst[k] <= k + 2, 1);
    chk({p, "full_lo"}, full[k] && sz < D, 0);
    chk({p, "full_hi"}, !full[k] && sz >= D + k + 2, 0);
    if (rst || init) begin
      if (k == 0) q0.delete(); else q1.delete();
      movf[k] = 1'b0;
      mudf[k] = 1'b0;
      outst[k] = 0;
    end else begin
      if (push) begin
        if (full[k]) movf[k] = 1'b1;
        else if (k == 0) q0.push_back(din);
        else q1.push_back(din);
      end
      if (pop[k]) begin
        if (!vld[k]) mudf[k] = 1'b1;
        else if (k == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
      outst[k] = outst[k] + int'(re[k]) - int'(pop[k] && vld[k]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0);
      mon(1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic setpop(input logic v);
    pop[0] = v;
    pop[1] = v;
  endtask

  task automatic chk_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst.vld", vld[k], 0);
      chk("rst.empty", empty[k], 1);
      chk("rst.aempty", aempty[k], 1);
      chk("rst.full", full[k], 0);
      chk("rst.afull", afull[k], 0);
      chk("rst.re", re[k], 0);
      chk("rst.we", we[k], 0);
      chk("rst.dout", dout[k], 0);
      chk("rst.cnt", cnt[k], 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    push = 1'b0;
    init = 1'b0;
    din = '0;
    setpop(1'b0);
    cyc();
    cyc();
    rst = 1'b0;
    mon_en = 1'b1;
    smp();
    chk_reset();

    // Single word latency
    cyc();
    push = 1'b1;
    din = 16'h00A5;
    cyc();
    push = 1'b0;
    smp();
    chk("t1.empty", empty[0], 0);
    chk("t1.cnt", cnt[0], 1);
    cyc();
    smp();
    chk("t1.vld_c2", vld[0], 0);
    cyc();
    smp();
    chk("t1.vld_c3", vld[0], 1);
    chk("t1.dout_c3", dout[0], 16'h00A5);
    chk("t1.vld_b_c3", vld[1], 0);
    cyc();
    smp();
    chk("t1.vld_b_c4", vld[1], 1);
    chk("t1.dout_b_c4", dout[1], 16'h00A5);
    cyc();
    setpop(1'b1);
    cyc();
    setpop(1'b0);

    // Fill to full, overflow, drain, underflow
    for (int i = 1; i <= 10; i++) begin
      push = 1'b1;
      din = W'(i);
      cyc();
    end
    din = 16'h000B;
    smp();
    chk("t2.full", full[0], 1);
    chk("t2.cnt", cnt[0], 10);
    cyc();
    push = 1'b0;
    smp();
    chk("t2.ovf", ovf[0], 1);
    chk("t2.cnt_drop", cnt[0], 10);
    cyc();
    setpop(1'b1);
    for (int i = 0; i < 14; i++) begin
      smp();
      if (i < 10) begin
        chk("t2.pop_vld", vld[0], 1);
        chk("t2.pop_data", dout[0], i + 1);
      end
      cyc();
    end
    setpop(1'b0);
    smp();
    chk("t2.empty", empty[0], 1);
    chk("t2.cnt0", cnt[0], 0);
    chk("t2.udf", udf[0], 1);
    cyc();
    init = 1'b1;
    cyc();
    init = 1'b0;
    smp();
    chk("t2.ovf_clr", ovf[0], 0);
    chk("t2.udf_clr", udf[0], 0);
    cyc();

    // Streaming, push and pop every cycle
    for (int c = 0; c < 46; c++) begin
      push = c < 40;
      din = W'(16'h0100 + c);
      for (int k = 0; k < 2; k++)
        pop[k] = (c >= 3 + k) && (c < 43 + k);
      smp();
      for (int k = 0; k < 2; k++) begin
        if (pop[k]) begin
          chk("t3.vld", vld[k], 1);
          chk("t3.data", dout[k], 16'h0100 + c - 3 - k);
        end
        if (c >= 3 + k && c <= 40) chk("t3.cnt", cnt[k], 3 + k);
      end
      cyc();
    end
    push = 1'b0;
    setpop(1'b0);

    // Flush with a read in flight
    for (int i = 0; i < 6; i++) begin
      push = 1'b1;
      din = W'(16'h0200 + i);
      cyc();
    end
    push = 1'b0;
    cyc();
    cyc();
    setpop(1'b1);
    cyc();
    setpop(1'b0);
    init = 1'b1;
    smp();
    chk("t4.pre_cnt", cnt[0], 5);
    cyc();
    init = 1'b0;
    for (int j = 0; j < 3; j++) begin
      smp();
      for (int k = 0; k < 2; k++) begin
        chk("t4.cnt", cnt[k], 0);
        chk("t4.vld", vld[k], 0);
      end
      cyc();
    end
    push = 1'b1;
    din = 16'h1234;
    cyc();
    push = 1'b0;
    cyc();
    cyc();
    cyc();
    smp();
    for (int k = 0; k < 2; k++) begin
      chk("t4.vld_new", vld[k], 1);
      chk("t4.data_new", dout[k], 16'h1234);
    end
    cyc();
    setpop(1'b1);
    cyc();
    setpop(1'b0);

    // Thresholds: fill to 6, drain to 0
    for (int i = 0; i <= 6; i++) begin
      push = i < 6;
      din = W'(16'h0300 + i);
      smp();
      for (int k = 0; k < 2; k++) begin
        chk("t5.afull_up", afull[k], i >= 6);
        chk("t5.aempty_up", aempty[k], i <= 2);
      end
      cyc();
    end
    push = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      setpop(i < 6);
      smp();
      for (int k = 0; k < 2; k++) begin
        chk("t5.afull_dn", afull[k], 6 - i >= 6);
        chk("t5.aempty_dn", aempty[k], 6 - i <= 2);
      end
      cyc();
    end
    setpop(1'b0);

    // Random traffic with a reset in the middle
    for (int i = 0; i < 800; i++) begin
      int hi;
      hi = (i / 100) % 2;
      rst = (i == 350);
      push = $urandom_range(0, 3) < (hi ? 3 : 1);
      din = W'($urandom);
      for (int k = 0; k < 2; k++)
        pop[k] = $urandom_range(0, 3) < (hi ? 1 : 3);
      if (i == 351) begin
        push = 1'b0;
        setpop(1'b0);
        smp();
        chk_reset();
        chk("t6.ovf", ovf[0] | ovf[1], 0);
        chk("t6.udf", udf[0] | udf[1], 0);
      end
      cyc();
    end
    rst = 1'b0;
    push = 1'b0;
    setpop(1'b1);
    for (int i = 0; i < 40 && !(empty[0] && empty[1]); i++)
      cyc();
    setpop(1'b0);
    smp();
    chk("t6.drain_a", empty[0], 1);
    chk("t6.drain_b", empty[1], 1);
    cyc();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
